riscv_regfile_mp: RTL



---
 rtl/riscv_regs_pkg.sv | 9 +
 rtl/riscv_regs_scoreboard.sv | 37 +++
 rtl/riscv_regfile_mp.sv | 74 +++++++
 3 files changed

// File: rtl/riscv_regs_pkg.sv
// riscv_regs_pkg: shared defaults, the x0 address and word/address types for the register file.
package riscv_regs_pkg;
    localparam int DEF_WORD_LENGTH = 32;
    localparam int DEF_ADDR_LENGTH = 5;
    localparam int DEF_NUM_REGS    = 32;
    localparam logic [DEF_ADDR_LENGTH-1:0] REG_ZERO = '0;
    typedef logic [DEF_ADDR_LENGTH-1:0] reg_addr_t;
    typedef logic [DEF_WORD_LENGTH-1:0] reg_word_t;
endpackage

// File: rtl/riscv_regs_scoreboard.sv
// riscv_regs_scoreboard: per-register pending-write bits.
// A new issue outranks flush, and flush outranks writeback clears.
module riscv_regs_scoreboard
    import riscv_regs_pkg::*;
#(
    parameter int ADDR_LENGTH = DEF_ADDR_LENGTH,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int NUM_WRITE   = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  issue_en_i,
    input  logic [ADDR_LENGTH-1:0]                issue_addr_i,
    input  logic                                  flush_i,
    input  logic [NUM_WRITE-1:0]                  clr_en_i,
    input  logic [NUM_WRITE-1:0][ADDR_LENGTH-1:0] clr_addr_i,
    output logic [NUM_REGS-1:0]                   busy_o
);
    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_d[r] = busy_q[r] && !flush_i;
            for (int k = 0; k < NUM_WRITE; k++)
                if (clr_en_i[k] && clr_addr_i[k] == ADDR_LENGTH'(r)) busy_d[r] = 1'b0;
            if (issue_en_i && issue_addr_i == ADDR_LENGTH'(r)) busy_d[r] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/riscv_regfile_mp.sv
// riscv_regfile_mp: multi-port integer register file with hardwired x0,
// optional write-to-read forwarding and a pending-write scoreboard.
module riscv_regfile_mp
    import riscv_regs_pkg::*;
#(
    parameter int WORD_LENGTH = DEF_WORD_LENGTH,
    parameter int ADDR_LENGTH = DEF_ADDR_LENGTH,
    parameter int NUM_REGS    = DEF_NUM_REGS,
    parameter int NUM_READ    = 2,
    parameter int NUM_WRITE   = 1,
    parameter int BYPASS      = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_READ-1:0][ADDR_LENGTH-1:0]  read_addr_i,
    output logic [NUM_READ-1:0][WORD_LENGTH-1:0]  read_data_o,
    output logic [NUM_READ-1:0]                   read_busy_o,
    input  logic [NUM_WRITE-1:0]                  write_en_i,
    input  logic [NUM_WRITE-1:0][ADDR_LENGTH-1:0] write_addr_i,
    input  logic [NUM_WRITE-1:0][WORD_LENGTH-1:0] write_data_i,
    input  logic                                  issue_en_i,
    input  logic [ADDR_LENGTH-1:0]                issue_addr_i,
    input  logic                                  flush_i
);
    logic [NUM_REGS-1:0][WORD_LENGTH-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]                  busy;

    riscv_regs_scoreboard #(
        .ADDR_LENGTH (ADDR_LENGTH),
        .NUM_REGS    (NUM_REGS),
        .NUM_WRITE   (NUM_WRITE)
    ) u_scoreboard (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_en_i   (issue_en_i),
        .issue_addr_i (issue_addr_i),
        .flush_i      (flush_i),
        .clr_en_i     (write_en_i),
        .clr_addr_i   (write_addr_i),
        .busy_o       (busy)
    );

    // Ascending port order lets the higher write port win on a collision.
    always_comb begin
        regs_d = regs_q;
        for (int r = 1; r < NUM_REGS; r++)
            for (int k = 0; k < NUM_WRITE; k++)
                if (write_en_i[k] && write_addr_i[k] == ADDR_LENGTH'(r)) regs_d[r] = write_data_i[k];
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    // Out-of-range addresses match no entry and read as zero, never busy.
    always_comb begin
        read_data_o = '0;
        read_busy_o = '0;
        for (int i = 0; i < NUM_READ; i++)
            for (int r = 0; r < NUM_REGS; r++)
                if (read_addr_i[i] == ADDR_LENGTH'(r)) begin
                    read_data_o[i] = regs_q[r];
                    read_busy_o[i] = busy[r];
                    if (BYPASS != 0 && rst_n && r != 0)
                        for (int k = 0; k < NUM_WRITE; k++)
                            if (write_en_i[k] && write_addr_i[k] == read_addr_i[i]) begin
                                read_data_o[i] = write_data_i[k];
                                read_busy_o[i] = 1'b0;
                            end
                end
    end
endmodule
